mc_ctrl: RTL and testbench

Multi-cycle main controller for the MIPS datapath. It decodes the opcode and funct fields latched in IR and steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK. In every cycle it drives the PC, IR, GRF and DM write enables, the extender mode (EXTOp), the ALU operation and the datapath muxes. It sits beside the IR and replaces the single-cycle combinational controller. It also keeps a count of retired instructions.

---
 rtl/mc_ctrl.sv | 156 +++++++++++++++
 tb/tb_mc_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS datapath.
//   Steps each instruction through FETCH/DCD/EXE/MEM/WB, driving the write
//   enables, extender mode, ALU op and datapath muxes from the current state
//   and the opcode/funct held in IR. Also counts retired instructions.
// Ports:
//   clk, reset (async, active-low)
//   opcode/funct  : IR[31:26] / IR[5:0]
//   zero          : ALU equality flag, used by beq
//   PCWr/IRWr/RFWr/DMWr : one-cycle write enables
//   EXTOp/ALUOp/ALUSrc/RegDst/WDSel/NPCOp : datapath controls
//   state         : current state code
//   instr_cnt     : retired-instruction count, wraps
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RFWr,
  output logic             DMWr,
  output logic [1:0]       EXTOp,
  output logic [2:0]       ALUOp,
  output logic             ALUSrc,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDSel,
  output logic [1:0]       NPCOp,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    S_FETCH = 3'b000,
    S_DCD   = 3'b001,
    S_EXE   = 3'b010,
    S_MEM   = 3'b011,
    S_WB    = 3'b100
  } st_e;

  st_e cur, nxt;

  // instruction decode; anything unmatched falls through as a NOP
  logic rtype, i_addu, i_subu, i_jr, i_ori, i_lw, i_sw, i_beq, i_lui, i_j, i_jal;
  logic is_jump, is_nop;

  assign rtype   = (opcode == 6'b000000);
  assign i_addu  = rtype && (funct == 6'b100001);
  assign i_subu  = rtype && (funct == 6'b100011);
  assign i_jr    = rtype && (funct == 6'b001000);
  assign i_ori   = (opcode == 6'b001101);
  assign i_lw    = (opcode == 6'b100011);
  assign i_sw    = (opcode == 6'b101011);
  assign i_beq   = (opcode == 6'b000100);
  assign i_lui   = (opcode == 6'b001111);
  assign i_j     = (opcode == 6'b000010);
  assign i_jal   = (opcode == 6'b000011);
  assign is_jump = i_j | i_jal | i_jr;
  assign is_nop  = ~(i_addu | i_subu | i_jr | i_ori | i_lw | i_sw |
                     i_beq | i_lui | i_j | i_jal);

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cur <= S_FETCH;
    else        cur <= nxt;
  end

  // next state
  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_FETCH: nxt = S_DCD;
      S_DCD:   nxt = (is_jump || is_nop) ? S_FETCH : S_EXE;
      S_EXE: begin
        if (i_lw || i_sw) nxt = S_MEM;
        else if (i_beq)   nxt = S_FETCH;
        else              nxt = S_WB;
      end
      S_MEM:   nxt = i_lw ? S_WB : S_FETCH;
      S_WB:    nxt = S_FETCH;
      default: nxt = S_FETCH;
    endcase
  end

  // outputs; all held at 0 while reset is asserted so the FETCH enables
  // cannot fire during reset
  always_comb begin
    PCWr   = 1'b0;
    IRWr   = 1'b0;
    RFWr   = 1'b0;
    DMWr   = 1'b0;
    EXTOp  = 2'b00;
    ALUOp  = 3'b000;
    ALUSrc = 1'b0;
    RegDst = 2'b00;
    WDSel  = 2'b00;
    NPCOp  = 2'b00;
    if (reset) begin
      case (cur)
        S_FETCH: begin
          IRWr = 1'b1;
          PCWr = 1'b1;
        end
        S_DCD: begin
          if (i_j || i_jal) begin
            PCWr  = 1'b1;
            NPCOp = 2'b10;
          end
          if (i_jr) begin
            PCWr  = 1'b1;
            NPCOp = 2'b11;
          end
          // PC and $31 commit on the same edge, so WDSel picks the
          // pre-edge PC+4
          if (i_jal) begin
            RFWr   = 1'b1;
            RegDst = 2'b10;
            WDSel  = 2'b10;
          end
        end
        S_EXE: begin
          if (i_subu) ALUOp = 3'b001;
          if (i_ori || i_lui) begin
            EXTOp  = i_ori ? 2'b01 : 2'b10;
            ALUSrc = 1'b1;
            ALUOp  = 3'b010;
          end
          if (i_lw || i_sw) ALUSrc = 1'b1;
          if (i_beq) begin
            ALUOp = 3'b001;
            NPCOp = 2'b01;
            PCWr  = zero;
          end
        end
        S_MEM: DMWr = i_sw;
        S_WB: begin
          RFWr = 1'b1;
          if (i_lw) WDSel = 2'b01;
          if (i_addu || i_subu) RegDst = 2'b01;
        end
        default: ;
      endcase
    end
  end

  // retire on any edge that re-enters FETCH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             instr_cnt <= '0;
    else if (nxt == S_FETCH && cur != S_FETCH) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  assign state = cur;

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  logic [5:0] opcode, funct;
  logic zero;
  logic PCWr, IRWr, RFWr, DMWr, ALUSrc;
  logic [1:0] EXTOp, RegDst, WDSel, NPCOp;
  logic [2:0] ALUOp, state;
  logic [CW-1:0] instr_cnt;

  mc_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr), .DMWr(DMWr), .EXTOp(EXTOp),
    .ALUOp(ALUOp), .ALUSrc(ALUSrc), .RegDst(RegDst), .WDSel(WDSel),
    .NPCOp(NPCOp), .state(state), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  // {PCWr,IRWr,RFWr,DMWr,EXTOp,ALUOp,ALUSrc,RegDst,WDSel,NPCOp,state}
  logic [18:0] act;
  assign act = {PCWr, IRWr, RFWr, DMWr, EXTOp, ALUOp, ALUSrc, RegDst, WDSel, NPCOp, state};

  int nvec = 0, nerr = 0;
  int unsigned mcnt = 0;

  typedef enum int {K_ADDU, K_SUBU, K_JR, K_ORI, K_LW, K_SW, K_BEQ, K_LUI, K_J, K_JAL, K_NOP} kind_e;

  function automatic kind_e kind_of(logic [5:0] op, logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21: return K_ADDU;
               6'h23: return K_SUBU;
               6'h08: return K_JR;
               default: return K_NOP;
             endcase
      6'h0d: return K_ORI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h0f: return K_LUI;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_NOP;
    endcase
  endfunction

  function automatic int seq_len(kind_e k);
    case (k)
      K_J, K_JAL, K_JR, K_NOP: return 2;
      K_BEQ: return 3;
      K_LW:  return 5;
      default: return 4;
    endcase
  endfunction

  // state visited in cycle c of an instruction: F, D, E, then M and/or W
  function automatic logic [2:0] seq_st(kind_e k, int c);
    case (c)
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
      default: return 3'd4;
    endcase
  endfunction

  // expected control word from the per-state action table
  function automatic logic [18:0] model(kind_e k, logic z, int c);
    logic pc, ir, rf, dm, src;
    logic [1:0] ext, rd, wd, npc;
    logic [2:0] alu, st;
    pc = 0; ir = 0; rf = 0; dm = 0; src = 0;
    ext = 0; rd = 0; wd = 0; npc = 0; alu = 0;
    st = seq_st(k, c);
    case (st)
      3'd0: begin ir = 1; pc = 1; end
      3'd1: begin
        if (k == K_J)   begin pc = 1; npc = 2'b10; end
        if (k == K_JAL) begin pc = 1; npc = 2'b10; rf = 1; rd = 2'b10; wd = 2'b10; end
        if (k == K_JR)  begin pc = 1; npc = 2'b11; end
      end
      3'd2: begin
        if (k == K_SUBU) alu = 3'b001;
        if (k == K_ORI) begin ext = 2'b01; src = 1; alu = 3'b010; end
        if (k == K_LUI) begin ext = 2'b10; src = 1; alu = 3'b010; end
        if (k == K_LW || k == K_SW) src = 1;
        if (k == K_BEQ) begin alu = 3'b001; npc = 2'b01; pc = z; end
      end
      3'd3: dm = (k == K_SW);
      default: begin
        rf = 1;
        if (k == K_LW) wd = 2'b01;
        if (k == K_ADDU || k == K_SUBU) rd = 2'b01;
      end
    endcase
    return {pc, ir, rf, dm, ext, alu, src, rd, wd, npc, st};
  endfunction

  task automatic chk(string nm, int c, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s cyc%0d: got %h want %h", nm, c, got, exp);
    end
  endtask

  // called #1 after an edge with the DUT in FETCH
  task automatic run_instr(logic [5:0] op, logic [5:0] fn, logic z, string nm);
    kind_e k;
    k = kind_of(op, fn);
    opcode = op; funct = fn; zero = z;
    for (int c = 0; c < seq_len(k); c++) begin
      @(negedge clk);
      chk(nm, c, 32'(act), 32'(model(k, z, c)));
      @(posedge clk); #1;
    end
    mcnt = (mcnt + 1) % (1 << CW);
    chk({nm, "_cnt"}, 99, {25'd0, state, instr_cnt}, {25'd0, 3'd0, 4'(mcnt)});
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    string      nm;
  } vec_t;

  vec_t tbl[$];

  initial begin
    logic [5:0] op, fn;
    reset = 1'b0; opcode = 0; funct = 0; zero = 0;
    #1;
    chk("rst_out", 0, 32'(act), 32'd0);
    chk("rst_cnt", 0, 32'(instr_cnt), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold", 0, 32'(act), 32'd0);
    reset = 1'b1;

    tbl.push_back('{6'h00, 6'h21, 1'b0, "addu"});
    tbl.push_back('{6'h23, 6'h00, 1'b0, "lw"});
    tbl.push_back('{6'h2b, 6'h00, 1'b0, "sw"});
    tbl.push_back('{6'h0d, 6'h01, 1'b0, "ori"});
    tbl.push_back('{6'h0f, 6'h34, 1'b0, "lui"});
    tbl.push_back('{6'h04, 6'h00, 1'b1, "beq_t"});
    tbl.push_back('{6'h04, 6'h00, 1'b0, "beq_nt"});
    tbl.push_back('{6'h03, 6'h00, 1'b0, "jal"});
    tbl.push_back('{6'h00, 6'h08, 1'b0, "jr"});
    tbl.push_back('{6'h3f, 6'h3f, 1'b1, "nop_op"});
    tbl.push_back('{6'h00, 6'h23, 1'b1, "subu"});
    tbl.push_back('{6'h02, 6'h00, 1'b0, "j"});
    tbl.push_back('{6'h00, 6'h20, 1'b0, "nop_fn"});
    foreach (tbl[i]) run_instr(tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].nm);

    // reset during EXE of addu: immediate clear, no WB write
    opcode = 6'h00; funct = 6'h21;
    @(posedge clk); @(posedge clk); #1;
    chk("pre_exe", 0, 32'(state), 32'd2);
    reset = 1'b0; #1;
    chk("mid_rst_out", 0, 32'(act), 32'd0);
    chk("mid_rst_cnt", 0, 32'(instr_cnt), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold", 1, 32'(act), 32'd0);
    reset = 1'b1;
    mcnt = 0;
    run_instr(6'h00, 6'h21, 1'b0, "addu_post");

    // randomized mix, counter wraps several times
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 11))
        0: begin op = 6'h00; fn = 6'h21; end
        1: begin op = 6'h00; fn = 6'h23; end
        2: begin op = 6'h00; fn = 6'h08; end
        3: begin op = 6'h00; fn = 6'($urandom); end
        4: op = 6'h0d;  5: op = 6'h23;  6: op = 6'h2b;  7: op = 6'h04;
        8: op = 6'h0f;  9: op = 6'h02; 10: op = 6'h03;
        default: op = 6'($urandom);
      endcase
      if (op != 6'h00) fn = 6'($urandom);
      run_instr(op, fn, 1'($urandom), "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
